// File: rtl/wb_router_pkg.sv
// Shared types and helpers for the Wishbone data-memory router.
package wb_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int unsigned WDOG_W               = 16;
    localparam int unsigned DEC_W                = 64;

    // True when the masked address lands in the m1 window.
    function automatic logic addr_in_m1(input logic [DEC_W-1:0] addr,
                                        input logic [DEC_W-1:0] base,
                                        input logic [DEC_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/wb_data_mem_router.sv
// Routes single Wishbone-classic core transactions to m0 or m1 by address,
// returns one ack per request and aborts slave accesses that never ack.
module wb_data_mem_router
    import wb_router_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] M1_BASE        = ADDR_WIDTH'(32'h0010_0000),
    parameter logic [ADDR_WIDTH-1:0] M1_MASK        = ADDR_WIDTH'(32'hFFF0_0000),
    parameter int unsigned           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(TIMEOUT_DATA_DEFAULT)
) (
    input  logic                  clk_core,
    input  logic                  rst_core,
    input  logic                  s_cyc_i,
    input  logic                  s_stb_i,
    input  logic                  s_we_i,
    input  logic [ADDR_WIDTH-1:0] s_addr_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic [DATA_WIDTH-1:0] s_data_o,
    output logic                  s_ack_o,
    output logic                  m0_cyc_o,
    output logic                  m0_stb_o,
    output logic                  m0_we_o,
    output logic [ADDR_WIDTH-1:0] m0_addr_o,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    input  logic                  m0_ack_i,
    output logic                  m1_cyc_o,
    output logic                  m1_stb_o,
    output logic                  m1_we_o,
    output logic [ADDR_WIDTH-1:0] m1_addr_o,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    input  logic                  m1_ack_i,
    output logic                  timeout_o,
    output logic [WDOG_W-1:0]     timeout_count_o
);

    localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  sel_q, sel_d;
    logic                  abort_q, abort_d;
    logic                  tmo_q, tmo_d;
    logic [WDOG_W-1:0]     wd_q, wd_d;
    logic [WDOG_W-1:0]     tcnt_q, tcnt_d;

    logic                  slv_ack;
    logic [DATA_WIDTH-1:0] slv_data;
    logic                  abort_now;
    logic                  busy0;
    logic                  busy1;

    // Only the selected slave can complete the access; a core abort is sticky.
    assign slv_ack   = sel_q ? m1_ack_i : m0_ack_i;
    assign slv_data  = sel_q ? m1_data_i : m0_data_i;
    assign abort_now = abort_q | ~s_cyc_i;

    // State and datapath registers.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            abort_q <= 1'b0;
            tmo_q   <= 1'b0;
            wd_q    <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            abort_q <= abort_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic: accept, wait for ack or watchdog, then respond.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        abort_d = abort_q;
        tmo_d   = 1'b0;
        wd_d    = wd_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    addr_d  = s_addr_i;
                    wdata_d = s_data_i;
                    we_d    = s_we_i;
                    sel_d   = addr_in_m1(DEC_W'(s_addr_i), DEC_W'(M1_BASE), DEC_W'(M1_MASK));
                    abort_d = 1'b0;
                    wd_d    = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                abort_d = abort_now;
                if (slv_ack) begin
                    rdata_d = we_q ? '0 : slv_data;
                    state_d = abort_now ? ST_IDLE : ST_RESP;
                end else if (wd_q == WD_LAST) begin
                    rdata_d = we_q ? '0 : TIMEOUT_DATA;
                    tmo_d   = 1'b1;
                    if (tcnt_q != '1) begin
                        tcnt_d = tcnt_q + WDOG_W'(1);
                    end
                    state_d = abort_now ? ST_IDLE : ST_RESP;
                end else begin
                    wd_d = wd_q + WDOG_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slave buses are driven from the latched request only while BUSY.
    assign busy0     = (state_q == ST_BUSY) && !sel_q;
    assign busy1     = (state_q == ST_BUSY) &&  sel_q;

    assign m0_cyc_o  = busy0;
    assign m0_stb_o  = busy0;
    assign m0_we_o   = busy0 & we_q;
    assign m0_addr_o = busy0 ? addr_q  : '0;
    assign m0_data_o = busy0 ? wdata_q : '0;

    assign m1_cyc_o  = busy1;
    assign m1_stb_o  = busy1;
    assign m1_we_o   = busy1 & we_q;
    assign m1_addr_o = busy1 ? addr_q  : '0;
    assign m1_data_o = busy1 ? wdata_q : '0;

    assign s_ack_o         = (state_q == ST_RESP);
    assign s_data_o        = rdata_q;
    assign timeout_o       = tmo_q;
    assign timeout_count_o = tcnt_q;

endmodule

// File: tb/tb_wb_data_mem_router.sv
// Scoreboard bench for wb_data_mem_router: the driver queues the expected
// response per request, a forked monitor checks every s_ack_o against it.
module tb_wb_data_mem_router;

    logic        clk_core = 1'b0;
    logic        rst_core;
    logic        s_cyc_i, s_stb_i, s_we_i;
    logic [31:0] s_addr_i, s_data_i, s_data_o;
    logic        s_ack_o;
    logic        m0_cyc_o, m0_stb_o, m0_we_o, m0_ack_i;
    logic [31:0] m0_addr_o, m0_data_o, m0_data_i;
    logic        m1_cyc_o, m1_stb_o, m1_we_o, m1_ack_i;
    logic [31:0] m1_addr_o, m1_data_o, m1_data_i;
    logic        timeout_o;
    logic [15:0] timeout_count_o;

    always #5 clk_core = ~clk_core;

    wb_data_mem_router #(.TIMEOUT_CYCLES(8)) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i),
        .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_data_o(s_data_o), .s_ack_o(s_ack_o),
        .m0_cyc_o(m0_cyc_o), .m0_stb_o(m0_stb_o), .m0_we_o(m0_we_o),
        .m0_addr_o(m0_addr_o), .m0_data_o(m0_data_o), .m0_data_i(m0_data_i), .m0_ack_i(m0_ack_i),
        .m1_cyc_o(m1_cyc_o), .m1_stb_o(m1_stb_o), .m1_we_o(m1_we_o),
        .m1_addr_o(m1_addr_o), .m1_data_o(m1_data_o), .m1_data_i(m1_data_i), .m1_ack_i(m1_ack_i),
        .timeout_o(timeout_o), .timeout_count_o(timeout_count_o)
    );

    // Slave models: ack after a programmable number of BUSY cycles.
    int   lat0 = 0, lat1 = 0, cnt0 = 0, cnt1 = 0;
    logic never0 = 1'b0, never1 = 1'b0, stray1 = 1'b0;
    logic [31:0] rd0 = '0, rd1 = '0;

    always @(posedge clk_core) begin
        cnt0 <= (m0_cyc_o && m0_stb_o) ? cnt0 + 1 : 0;
        cnt1 <= (m1_cyc_o && m1_stb_o) ? cnt1 + 1 : 0;
    end
    assign m0_ack_i  = m0_cyc_o & m0_stb_o & !never0 & (cnt0 == lat0);
    assign m1_ack_i  = stray1 | (m1_cyc_o & m1_stb_o & !never1 & (cnt1 == lat1));
    assign m0_data_i = rd0;
    assign m1_data_i = rd1;

    int cyc_cnt = 0;
    always @(posedge clk_core) cyc_cnt <= cyc_cnt + 1;

    logic [66:0]  m0bus, m1bus;
    logic [183:0] all_outs;
    assign m0bus    = {m0_cyc_o, m0_stb_o, m0_we_o, m0_addr_o, m0_data_o};
    assign m1bus    = {m1_cyc_o, m1_stb_o, m1_we_o, m1_addr_o, m1_data_o};
    assign all_outs = {s_ack_o, s_data_o, m0bus, m1bus, timeout_o, timeout_count_o};

    typedef struct {
        logic [31:0] data;
        int          cyc;
        logic        tmo;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    int chk = 0, err = 0;
    int ack_cnt = 0, m0_hi = 0, m1_hi = 0, overlap = 0;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Pops the oldest expectation on each core ack.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_core);
            if (!rst_core && s_ack_o) begin
                ack_cnt++;
                if (sb.size() == 0) begin
                    chk++;
                    err++;
                    $display("FAIL unexpected_ack: got ack at cycle %0d want none", cyc_cnt);
                end else begin
                    e = sb.pop_front();
                    check("ack_data", s_data_o, e.data);
                    check("ack_cycle", cyc_cnt, e.cyc);
                    check("ack_timeout", timeout_o, e.tmo);
                    check("ack_tcount", timeout_count_o, e.cnt);
                end
            end
        end
    endtask

    // Counts cycles each slave cycle is high, sampled mid-cycle.
    task automatic bus_watch();
        forever begin
            @(posedge clk_core);
            #2;
            if (m0_cyc_o) m0_hi++;
            if (m1_cyc_o) m1_hi++;
            if (m0_cyc_o && m1_cyc_o) overlap++;
        end
    endtask

    // One core transaction; off = cycles from request to expected s_ack_o.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] sdata, input logic never, input int off,
                          input logic [31:0] exp_data, input logic exp_tmo, input logic [15:0] exp_cnt);
        logic sel;
        int   h0, h1;
        logic got;
        exp_t e;
        sel = ((addr & 32'hFFF0_0000) == 32'h0010_0000);
        if (sel) begin lat1 = off - 2; never1 = never; rd1 = sdata; end
        else     begin lat0 = off - 2; never0 = never; rd0 = sdata; end
        @(posedge clk_core);
        #1;
        h0 = m0_hi;
        h1 = m1_hi;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_addr_i = addr; s_data_i = wdata;
        e.data = exp_data; e.cyc = cyc_cnt + off; e.tmo = exp_tmo; e.cnt = exp_cnt;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_core);
            if (i == 1) begin
                check("busy_sel_bus", sel ? m1bus : m0bus, {1'b1, 1'b1, we, addr, wdata});
                check("busy_unsel_bus", sel ? m0bus : m1bus, 0);
            end
            if (s_ack_o) got = 1'b1;
        end
        check("ack_within_bound", got, 1);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        check("sel_cyc_cycles", sel ? m1_hi - h1 : m0_hi - h0, off - 1);
        check("unsel_cyc_cycles", sel ? m0_hi - h0 : m1_hi - h1, 0);
    endtask

    initial begin
        int a0, h0;
        rst_core = 1'b1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; s_addr_i = '0; s_data_i = '0;
        fork
            monitor();
            bus_watch();
        join_none

        repeat (2) @(posedge clk_core);
        #1;
        check("reset_outputs", all_outs, 0);
        @(negedge clk_core);
        rst_core = 1'b0;
        @(negedge clk_core);
        check("idle_outputs", all_outs, 0);

        // m0 read, 3-cycle slave; a stray m1 ack must be ignored.
        stray1 = 1'b1; rd1 = 32'hBAD0_BAD0;
        do_req(1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1'b0, 5, 32'h1234_5678, 1'b0, 16'd0);
        stray1 = 1'b0;
        // m1 write: response data must be 0 whatever the slave drives.
        do_req(1'b1, 32'h0010_0008, 32'hCAFE_F00D, 32'h5555_AAAA, 1'b0, 4, 32'h0, 1'b0, 16'd0);
        // m1 read with no ack: 8 BUSY cycles then abort.
        do_req(1'b0, 32'h0010_0000, 32'h0, 32'h0, 1'b1, 9, 32'hDEAD_BEEF, 1'b1, 16'd1);
        // m1 ack on the last watchdog cycle wins over the timeout.
        do_req(1'b0, 32'h001F_FFFC, 32'h0, 32'hA5A5_0001, 1'b0, 9, 32'hA5A5_0001, 1'b0, 16'd1);
        // Back-to-back zero-wait reads: just below the window, then inside it.
        do_req(1'b0, 32'h000F_FFFC, 32'h0, 32'h1111_2222, 1'b0, 2, 32'h1111_2222, 1'b0, 16'd1);
        do_req(1'b0, 32'h0010_0004, 32'h0, 32'h3333_4444, 1'b0, 2, 32'h3333_4444, 1'b0, 16'd1);
        // Timed-out write returns 0 data.
        do_req(1'b1, 32'h0010_0020, 32'h7777_8888, 32'h0, 1'b1, 9, 32'h0, 1'b1, 16'd2);

        // Core abort: drop s_cyc_i in BUSY; slave runs to ack, no core ack.
        lat0 = 3; never0 = 1'b0; rd0 = 32'h9999_AAAA;
        @(posedge clk_core);
        #1;
        a0 = ack_cnt;
        h0 = m0_hi;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h0000_0200; s_data_i = '0;
        @(posedge clk_core);
        #1;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        repeat (10) @(posedge clk_core);
        #1;
        check("abort_no_ack", ack_cnt - a0, 0);
        check("abort_slave_cycles", m0_hi - h0, 4);
        check("abort_bus_idle", {m0bus, m1bus}, 0);

        // Reset in BUSY drops the slave bus at once and clears everything.
        never1 = 1'b1; rd1 = 32'h0;
        @(posedge clk_core);
        #1;
        s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h0010_0010;
        repeat (3) @(posedge clk_core);
        #1;
        check("pre_reset_busy", m1_cyc_o, 1);
        rst_core = 1'b1;
        #1;
        check("midreset_outputs", all_outs, 0);
        s_cyc_i = 1'b0; s_stb_i = 1'b0; never1 = 1'b0;
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        rst_core = 1'b0;

        // Outside-window address goes to m0; count restarted from 0.
        do_req(1'b0, 32'h0020_0000, 32'h0, 32'h0BAD_F00D, 1'b0, 3, 32'h0BAD_F00D, 1'b0, 16'd0);

        repeat (3) @(posedge clk_core);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        check("no_cyc_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
